// File: rtl/n64_vinfo_ext_pkg.sv
// Shared constants, types and helpers for the N64 video-bus front-end decoder.
// The bus carries one pixel as four nCLK slots: sync, R, G, B.
package n64_vinfo_ext_pkg;

  localparam int color_width_i = 7;
  localparam int SYNC_W        = 4;
  localparam int VDATA_W       = 3 * color_width_i + SYNC_W;
  localparam int LINE_CNT_W    = 10;

  localparam logic [LINE_CNT_W-1:0] LINE_PAL_TH  = LINE_CNT_W'(280);
  localparam logic [LINE_CNT_W-1:0] LINE_CNT_MAX = '1;

  // Sync-slot bit positions on D_i and inside the stored sync field
  localparam int SYNC_NVSYNC = 3;
  localparam int SYNC_NCLAMP = 2;
  localparam int SYNC_NHSYNC = 1;
  localparam int SYNC_NCSYNC = 0;

  // Field LSB positions inside vdata_r = {sync, R, G, B}
  localparam int VDATA_FU_LSB = 3 * color_width_i;
  localparam int VDATA_RE_LSB = 2 * color_width_i;
  localparam int VDATA_GR_LSB = color_width_i;
  localparam int VDATA_BL_LSB = 0;

  typedef enum logic [1:0] {
    SLOT_SYNC = 2'd0,
    SLOT_R    = 2'd1,
    SLOT_G    = 2'd2,
    SLOT_B    = 2'd3
  } slot_e;

  typedef enum logic [1:0] {
    FD_P240      = 2'd0,
    FD_P240_CAND = 2'd1,
    FD_I480_CAND = 2'd2,
    FD_I480      = 2'd3
  } field_state_e;

  function automatic logic is_480i(input field_state_e s);
    return (s == FD_I480) || (s == FD_I480_CAND);
  endfunction

  function automatic logic [VDATA_W-1:0] pack_vdata(
    input logic [SYNC_W-1:0]        sync,
    input logic [color_width_i-1:0] red,
    input logic [color_width_i-1:0] green,
    input logic [color_width_i-1:0] blue
  );
    return {sync, red, green, blue};
  endfunction

endpackage

// File: rtl/n64_vinfo_ext_if.sv
// Video-bus bundle between the N64 pixel bus source and the decoder.
// The bus is free-running with no valid/ready: every nCLK falling edge carries one slot, and the
// decoder can never stall it; the outputs are registered and valid every cycle after reset.
interface n64_vinfo_ext_if;
  import n64_vinfo_ext_pkg::*;

  logic                     nDSYNC;
  logic [color_width_i-1:0] D_i;

  logic [1:0]               data_cnt;
  logic [VDATA_W-1:0]       vdata_r;
  logic                     blurry_pixel_pos;
  logic                     n64_480i;
  logic                     vmode;
  logic                     new_frame;

  logic [LINE_CNT_W-1:0]    line_cnt;
  field_state_e             field_state;

  modport master (
    output nDSYNC, D_i,
    input  data_cnt, vdata_r, blurry_pixel_pos, n64_480i, vmode, new_frame,
    input  line_cnt, field_state
  );

  modport slave (
    input  nDSYNC, D_i,
    output data_cnt, vdata_r, blurry_pixel_pos, n64_480i, vmode, new_frame,
    output line_cnt, field_state
  );

endinterface

// File: rtl/n64_vinfo_ext_field_det.sv
// 240p / 480i field detector: compares the nHSYNC level seen at each vsync edge with the
// previous field's level; two agreeing observations in a row are needed to change mode.
module n64_field_det
  import n64_vinfo_ext_pkg::*;
(
  input  logic         nCLK,
  input  logic         RST,
  input  logic         vsync_edge_i,
  input  logic         nhsync_i,
  output logic         n64_480i_o,
  output field_state_e state_o
);

  field_state_e state_q, state_d;
  logic         have_q, have_d;
  logic         prev_q, prev_d;
  logic         i480_q, i480_d;
  logic         alt;

  always_ff @(negedge nCLK or posedge RST) begin
    if (RST) begin
      state_q <= FD_P240;
      have_q  <= 1'b0;
      prev_q  <= 1'b0;
      i480_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      have_q  <= have_d;
      prev_q  <= prev_d;
      i480_q  <= i480_d;
    end
  end

  always_comb begin
    state_d = state_q;
    have_d  = have_q;
    prev_d  = prev_q;
    alt     = nhsync_i ^ prev_q;

    if (vsync_edge_i) begin
      have_d = 1'b1;
      prev_d = nhsync_i;
      // The first field after reset has nothing to compare against.
      if (have_q) begin
        case (state_q)
          FD_P240:      state_d = alt ? FD_P240_CAND : FD_P240;
          FD_P240_CAND: state_d = alt ? FD_I480      : FD_P240;
          FD_I480:      state_d = alt ? FD_I480      : FD_I480_CAND;
          FD_I480_CAND: state_d = alt ? FD_I480      : FD_P240;
          default:      state_d = FD_P240;
        endcase
      end
    end

    i480_d = is_480i(state_d);
  end

  assign n64_480i_o = i480_q;
  assign state_o    = state_q;

endmodule

// File: rtl/n64_vinfo_ext.sv
// N64 multiplexed video-bus decoder: slot counter, whole-pixel capture, sync edge detection,
// pixel-phase toggle, line counting for NTSC/PAL and the 240p/480i field detector.
module n64_vinfo_ext
  import n64_vinfo_ext_pkg::*;
(
  input  logic          nCLK,
  input  logic          RST,
  n64_vinfo_ext_if.slave bus
);

  logic [1:0]               data_cnt_q, data_cnt_d;
  logic [SYNC_W-1:0]        sync_q, sync_d;
  logic [color_width_i-1:0] red_q, red_d;
  logic [color_width_i-1:0] green_q, green_d;
  logic [color_width_i-1:0] blue_q, blue_d;
  logic                     blurry_q, blurry_d;
  logic [LINE_CNT_W-1:0]    line_cnt_q, line_cnt_d;
  logic                     vmode_q, vmode_d;
  logic                     field_seen_q, field_seen_d;
  logic                     new_frame_q, new_frame_d;

  logic                     sync_slot;
  logic                     nv_edge;
  logic                     nh_edge;
  logic                     fd_480i;
  field_state_e             fd_state;

  assign sync_slot = ~bus.nDSYNC;
  assign nv_edge   = sync_slot & sync_q[SYNC_NVSYNC] & ~bus.D_i[SYNC_NVSYNC];
  assign nh_edge   = sync_slot & sync_q[SYNC_NHSYNC] & ~bus.D_i[SYNC_NHSYNC];

  always_ff @(negedge nCLK or posedge RST) begin
    if (RST) begin
      data_cnt_q   <= SLOT_SYNC;
      sync_q       <= '1;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      blurry_q     <= 1'b1;
      line_cnt_q   <= '0;
      vmode_q      <= 1'b0;
      field_seen_q <= 1'b0;
      new_frame_q  <= 1'b0;
    end else begin
      data_cnt_q   <= data_cnt_d;
      sync_q       <= sync_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      blurry_q     <= blurry_d;
      line_cnt_q   <= line_cnt_d;
      vmode_q      <= vmode_d;
      field_seen_q <= field_seen_d;
      new_frame_q  <= new_frame_d;
    end
  end

  always_comb begin
    data_cnt_d   = data_cnt_q + 2'd1;
    sync_d       = sync_q;
    red_d        = red_q;
    green_d      = green_q;
    blue_d       = blue_q;
    blurry_d     = blurry_q;
    line_cnt_d   = line_cnt_q;
    vmode_d      = vmode_q;
    field_seen_d = field_seen_q;
    new_frame_d  = nv_edge;

    if (sync_slot) begin
      data_cnt_d = SLOT_R;
      sync_d     = bus.D_i[SYNC_W-1:0];
      blurry_d   = nh_edge ? 1'b1 : ~blurry_q;
      // vmode is only trusted once a whole field has been counted since reset.
      if (nv_edge) begin
        if (field_seen_q) begin
          vmode_d = (line_cnt_q > LINE_PAL_TH);
        end
        field_seen_d = 1'b1;
        line_cnt_d   = '0;
      end else if (nh_edge && (line_cnt_q != LINE_CNT_MAX)) begin
        line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
      end
    end else begin
      case (data_cnt_q)
        SLOT_R:  red_d   = bus.D_i;
        SLOT_G:  green_d = bus.D_i;
        SLOT_B:  blue_d  = bus.D_i;
        default: ;
      endcase
    end
  end

  n64_field_det u_field_det (
    .nCLK         (nCLK),
    .RST          (RST),
    .vsync_edge_i (nv_edge),
    .nhsync_i     (bus.D_i[SYNC_NHSYNC]),
    .n64_480i_o   (fd_480i),
    .state_o      (fd_state)
  );

  assign bus.data_cnt         = data_cnt_q;
  assign bus.vdata_r          = pack_vdata(sync_q, red_q, green_q, blue_q);
  assign bus.blurry_pixel_pos = blurry_q;
  assign bus.n64_480i         = fd_480i;
  assign bus.vmode            = vmode_q;
  assign bus.new_frame        = new_frame_q;
  assign bus.line_cnt         = line_cnt_q;
  assign bus.field_state      = fd_state;

endmodule

// File: tb/tb_n64_vinfo_ext.sv
// Bench for n64_vinfo_ext: slot-level driver, pixel/field-level behavioural model, expected queue.
module tb_n64_vinfo_ext;
  import n64_vinfo_ext_pkg::*;

  localparam int CW = color_width_i;
  localparam int VW = 2 + VDATA_W + 4 + LINE_CNT_W;
  localparam int LINES_MAX = (1 << LINE_CNT_W) - 1;

  logic nCLK;
  logic RST;

  n64_vinfo_ext_if bus();

  n64_vinfo_ext dut (
    .nCLK (nCLK),
    .RST  (RST),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial nCLK = 1'b1;
  always #5 nCLK = ~nCLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model state ----------------
  int total;
  int bad;
  int nf_dut;
  int nf_model;

  logic [1:0]    m_cnt;
  logic [3:0]    m_sync;
  logic [CW-1:0] m_r, m_g, m_b;
  logic          m_blurry, m_vmode, m_nf;
  int            m_lines;
  bit            m_seen, m_have, m_prev;
  bit            alt_q[$];

  logic [VW-1:0] exp_q[$];

  function automatic void model_reset();
    m_cnt    = 2'd0;
    m_sync   = 4'hF;
    m_r      = '0;
    m_g      = '0;
    m_b      = '0;
    m_blurry = 1'b1;
    m_vmode  = 1'b0;
    m_nf     = 1'b0;
    m_lines  = 0;
    m_seen   = 1'b0;
    m_have   = 1'b0;
    m_prev   = 1'b0;
    alt_q.delete();
    exp_q.delete();
  endfunction

  // Interlace flag from the history of "did nHSYNC-at-vsync differ from last field":
  // the mode flips only after two consecutive observations that disagree with it.
  function automatic bit model_480i();
    bit mode = 1'b0;
    int streak = 0;
    foreach (alt_q[i]) begin
      if (alt_q[i] != mode) begin
        streak++;
        if (streak == 2) begin
          mode   = !mode;
          streak = 0;
        end
      end else begin
        streak = 0;
      end
    end
    return mode;
  endfunction

  function automatic void model_slot(input logic nd, input logic [CW-1:0] d);
    bit v_fall, h_fall;
    v_fall = !nd && m_sync[3] && !d[3];
    h_fall = !nd && m_sync[1] && !d[1];
    m_nf   = v_fall;
    if (!nd) begin
      m_blurry = h_fall ? 1'b1 : !m_blurry;
      if (v_fall) begin
        if (m_seen) m_vmode = (m_lines > 280);
        m_seen  = 1'b1;
        m_lines = 0;
        if (m_have) alt_q.push_back(d[1] ^ m_prev);
        m_have = 1'b1;
        m_prev = d[1];
      end else if (h_fall && m_lines < LINES_MAX) begin
        m_lines++;
      end
      m_sync = d[3:0];
      m_cnt  = 2'd1;
    end else begin
      if (m_cnt == 2'd1) m_r = d;
      if (m_cnt == 2'd2) m_g = d;
      if (m_cnt == 2'd3) m_b = d;
      m_cnt = 2'((int'(m_cnt) + 1) % 4);
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [LINE_CNT_W-1:0] l;
    l = LINE_CNT_W'(m_lines);
    return {m_cnt, m_sync, m_r, m_g, m_b, m_blurry, model_480i(), m_vmode, m_nf, l};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.data_cnt, bus.vdata_r, bus.blurry_pixel_pos, bus.n64_480i,
            bus.vmode, bus.new_frame, bus.line_cnt};
  endfunction

  function automatic logic [CW-1:0] rnd_c();
    return CW'($urandom_range(0, (1 << CW) - 1));
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input logic nd, input logic [CW-1:0] d);
    bus.nDSYNC = nd;
    bus.D_i    = d;
    @(negedge nCLK);
    #1;
    model_slot(nd, d);
    exp_q.push_back(model_vec());
    if (bus.new_frame === 1'b1) nf_dut++;
    if (m_nf) nf_model++;
  endtask

  task automatic send_word(input logic [3:0] s);
    step(1'b0, {3'b000, s});
    step(1'b1, rnd_c());
    step(1'b1, rnd_c());
    step(1'b1, rnd_c());
  endtask

  task automatic send_lines(input int n);
    for (int l = 0; l < n; l++) begin
      send_word(4'hF);
      send_word(4'b1101);
    end
  endtask

  task automatic vsync_slot(input logic hs);
    step(1'b0, {3'b000, 1'b0, 1'b1, hs, 1'b1});
  endtask

  task automatic finish_vsync_word();
    step(1'b1, rnd_c());
    step(1'b1, rnd_c());
    step(1'b1, rnd_c());
    send_word(4'hF);
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    @(negedge nCLK);
    #1;
    model_reset();
    RST = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [VW-1:0] exp_v;
    RST        = 1'b1;
    bus.nDSYNC = 1'b1;
    bus.D_i    = '0;
    repeat (3) @(negedge nCLK);
    #1;
    model_reset();
    exp_v = model_vec();
    total++;
    if (dut_vec() !== exp_v) begin
      bad++;
      $display("FAIL reset_state: got=%h exp=%h", dut_vec(), exp_v);
    end
    RST = 1'b0;
  endtask

  task automatic test_capture();
    logic [1:0]      cnt_seq[4];
    logic [3*CW-1:0] rgb_exp;
    logic [CW-1:0]   slot_d[4];
    logic [VW-1:0]   exp_v;
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    rgb_exp = {7'h11, 7'h22, 7'h33};
    slot_d  = '{7'h0F, 7'h11, 7'h22, 7'h33};
    exp_q.delete();
    for (int s = 0; s < 4; s++) begin
      step(s != 0, slot_d[s]);
      total++;
      if (bus.data_cnt !== cnt_seq[s]) begin
        bad++;
        $display("FAIL capture_cnt[%0d]: got=%0d exp=%0d", s, bus.data_cnt, cnt_seq[s]);
      end
    end
    total++;
    if (bus.vdata_r[3*CW-1:0] !== rgb_exp) begin
      bad++;
      $display("FAIL capture_rgb: got=%h exp=%h", bus.vdata_r[3*CW-1:0], rgb_exp);
    end
    exp_q.delete();
    for (int w = 0; w < 6; w++) begin
      send_word(4'hF);
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        total++;
        if (dut_vec() !== exp_v && exp_q.size() == 0) begin
          bad++;
          $display("FAIL capture_word[%0d]: got=%h exp=%h", w, dut_vec(), exp_v);
        end else if (exp_q.size() != 0) begin
          total--;
        end
      end
    end
  endtask

  task automatic test_240p();
    logic [VW-1:0] exp_v;
    for (int f = 0; f < 3; f++) begin
      nf_dut   = 0;
      nf_model = 0;
      send_lines(262);
      vsync_slot(1'b0);
      exp_v = exp_q[$];
      exp_q.delete();
      total++;
      if (dut_vec() !== exp_v) begin
        bad++;
        $display("FAIL p240_vsync[%0d]: got=%h exp=%h", f, dut_vec(), exp_v);
      end
      total++;
      if (nf_dut != 1 || nf_model != 1) begin
        bad++;
        $display("FAIL p240_new_frame_count[%0d]: got=%0d exp=1", f, nf_dut);
      end
      if (f >= 1) begin
        total++;
        if (bus.n64_480i !== 1'b0 || bus.vmode !== 1'b0) begin
          bad++;
          $display("FAIL p240_flags[%0d]: got=%b%b exp=00", f, bus.n64_480i, bus.vmode);
        end
      end
      finish_vsync_word();
      exp_q.delete();
    end
  endtask

  task automatic test_480i();
    logic          hs_seq[7];
    logic          i480_exp[7];
    logic [VW-1:0] exp_v;
    hs_seq   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    i480_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int f = 0; f < 7; f++) begin
      send_lines(30);
      vsync_slot(hs_seq[f]);
      exp_v = exp_q[$];
      exp_q.delete();
      total++;
      if (bus.n64_480i !== i480_exp[f]) begin
        bad++;
        $display("FAIL i480_flag[%0d]: got=%b exp=%b", f, bus.n64_480i, i480_exp[f]);
      end
      total++;
      if (dut_vec() !== exp_v) begin
        bad++;
        $display("FAIL i480_vsync[%0d]: got=%h exp=%h", f, dut_vec(), exp_v);
      end
      finish_vsync_word();
      exp_q.delete();
    end
  endtask

  task automatic test_pal();
    int            n_lines[2];
    logic          vm_exp[2];
    logic [VW-1:0] exp_v;
    n_lines = '{312, 262};
    vm_exp  = '{1'b1, 1'b0};
    for (int f = 0; f < 2; f++) begin
      send_lines(n_lines[f]);
      vsync_slot(1'b0);
      exp_v = exp_q[$];
      exp_q.delete();
      total++;
      if (bus.vmode !== vm_exp[f]) begin
        bad++;
        $display("FAIL pal_vmode[%0d]: got=%b exp=%b", f, bus.vmode, vm_exp[f]);
      end
      total++;
      if (dut_vec() !== exp_v) begin
        bad++;
        $display("FAIL pal_vsync[%0d]: got=%h exp=%h", f, dut_vec(), exp_v);
      end
      finish_vsync_word();
      exp_q.delete();
    end
  endtask

  task automatic test_coincident();
    logic [VW-1:0] exp_v;
    send_word(4'hF);
    send_word(4'hF);
    if (m_blurry == 1'b0) send_word(4'hF);
    step(1'b0, 7'b000_1101);
    exp_v = exp_q[$];
    exp_q.delete();
    total++;
    if (bus.blurry_pixel_pos !== 1'b1 || dut_vec() !== exp_v) begin
      bad++;
      $display("FAIL hsync_over_toggle: got=%h exp=%h", dut_vec(), exp_v);
    end
    step(1'b1, rnd_c());
    step(1'b1, rnd_c());
    step(1'b1, rnd_c());
    send_word(4'hF);
    step(1'b0, 7'b000_0101);
    exp_v = exp_q[$];
    exp_q.delete();
    total++;
    if (bus.line_cnt !== '0 || bus.blurry_pixel_pos !== 1'b1 || bus.new_frame !== 1'b1) begin
      bad++;
      $display("FAIL hv_coincident: got=cnt%0d/blur%b/nf%b exp=cnt0/blur1/nf1",
               bus.line_cnt, bus.blurry_pixel_pos, bus.new_frame);
    end
    total++;
    if (dut_vec() !== exp_v) begin
      bad++;
      $display("FAIL hv_coincident_vec: got=%h exp=%h", dut_vec(), exp_v);
    end
    step(1'b1, rnd_c());
    total++;
    if (bus.new_frame !== 1'b0) begin
      bad++;
      $display("FAIL new_frame_width: got=%b exp=0", bus.new_frame);
    end
    step(1'b1, rnd_c());
    step(1'b1, rnd_c());
    send_word(4'hF);
    exp_q.delete();
  endtask

  task automatic test_saturation();
    for (int l = 0; l < LINES_MAX + 8; l++) begin
      step(1'b0, 7'h0F);
      step(1'b0, 7'h0D);
    end
    exp_q.delete();
    total++;
    if (bus.line_cnt !== LINE_CNT_W'(LINES_MAX) || m_lines != LINES_MAX) begin
      bad++;
      $display("FAIL line_saturate: got=%0d exp=%0d", bus.line_cnt, LINES_MAX);
    end
    step(1'b0, 7'h05);
    exp_q.delete();
    total++;
    if (bus.vmode !== 1'b1 || bus.line_cnt !== '0) begin
      bad++;
      $display("FAIL sat_vsync: got=vm%b/cnt%0d exp=vm1/cnt0", bus.vmode, bus.line_cnt);
    end
    finish_vsync_word();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] exp_v;
    send_word(4'hF);
    step(1'b0, 7'h0F);
    step(1'b1, rnd_c());
    bus.nDSYNC = 1'b1;
    bus.D_i    = rnd_c();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    exp_v = model_vec();
    total++;
    if (bus.data_cnt !== 2'd0 || bus.vdata_r[VDATA_W-1 -: 4] !== 4'hF) begin
      bad++;
      $display("FAIL rst_mid_async: got=cnt%0d/sync%h exp=cnt0/syncF",
               bus.data_cnt, bus.vdata_r[VDATA_W-1 -: 4]);
    end
    total++;
    if (dut_vec() !== exp_v) begin
      bad++;
      $display("FAIL rst_mid_vec: got=%h exp=%h", dut_vec(), exp_v);
    end
    @(negedge nCLK);
    #1;
    RST = 1'b0;
    step(1'b1, rnd_c());
    step(1'b1, rnd_c());
    exp_q.delete();
    for (int w = 0; w < 3; w++) begin
      send_word(4'hF);
      exp_v = exp_q[$];
      exp_q.delete();
      total++;
      if (dut_vec() !== exp_v) begin
        bad++;
        $display("FAIL rst_resume[%0d]: got=%h exp=%h", w, dut_vec(), exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] exp_v;
    logic          nd;
    logic [CW-1:0] d;
    exp_q.delete();
    for (int s = 0; s < 300; s++) begin
      nd = ($urandom_range(0, 3) != 0);
      d  = nd ? rnd_c() : {3'b000, 4'($urandom_range(0, 15))};
      step(nd, d);
      exp_v = exp_q.pop_front();
      total++;
      if (dut_vec() !== exp_v) begin
        bad++;
        $display("FAIL random_slot[%0d]: got=%h exp=%h", s, dut_vec(), exp_v);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total    = 0;
    bad      = 0;
    nf_dut   = 0;
    nf_model = 0;
    test_reset();
    test_capture();
    test_240p();
    test_480i();
    test_pal();
    test_coincident();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
